// File: rtl/arb_pkg.sv
// Shared types and sizing for the 4-way round-robin arbiter.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_REQ-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: rotate req so ptr lands at bit 0, then
// take the lowest set bit and map its offset back to an absolute index.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     off;

    assign dbl = {req, req};
    assign rot = dbl[ptr +: NUM_REQ];

    always_comb begin
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
    end

    assign idx = ptr + off;
    assign any = |req;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for 4 requesters with done-release and a hold limit
// that forcibly revokes a grant after MAX_HOLD cycles.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_id,
    output logic               busy,
    output logic               timeout
);

    localparam int CW = $clog2(MAX_HOLD) + 1;

    state_t         state;
    logic [IDX_W-1:0] ptr;
    logic [CW-1:0]  cnt;
    logic [IDX_W-1:0] pick_idx;
    logic           pick_any;
    logic           limit;
    logic           owner_req;
    logic           release_now;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign limit       = (cnt == CW'(MAX_HOLD - 1));
    assign owner_req   = req[gnt_id];
    assign release_now = done || !owner_req || limit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE, RELEASE: begin
                    // RELEASE arbitrates with the ptr already advanced on entry
                    if (pick_any) begin
                        state  <= GRANT;
                        gnt    <= onehot(pick_idx);
                        gnt_id <= pick_idx;
                        busy   <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        state  <= IDLE;
                        gnt    <= '0;
                        gnt_id <= '0;
                        busy   <= 1'b0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state   <= RELEASE;
                        gnt     <= '0;
                        gnt_id  <= '0;
                        busy    <= 1'b0;
                        cnt     <= '0;
                        ptr     <= gnt_id + IDX_W'(1);
                        // only a pure hold-limit exit is reported as a timeout
                        timeout <= limit && !done && owner_req;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    gnt    <= '0;
                    gnt_id <= '0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: each expected grant (vector, id, length,
// timeout flag) is queued by the stimulus and checked by a negedge monitor.
module tb_rr_arbiter;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       done = 1'b0;
    logic [3:0] req  = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    always #5 clk = ~clk;

    rr_arbiter #(.MAX_HOLD(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    typedef struct {
        logic [3:0] g;
        logic [1:0] id;
        int         len;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   errors = 0;
    int   checks = 0;
    int   len    = 0;
    logic busy_q = 1'b0;
    logic to_q   = 1'b0;
    logic active = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [1:0] id, input int l, input logic to);
        exp_t e;
        e.g = g; e.id = id; e.len = l; e.to = to;
        exp_q.push_back(e);
    endtask

    // monitor: grant start pops an expectation, grant end checks length/timeout
    always @(negedge clk) begin
        if (busy && !busy_q) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: got gnt=%b with empty scoreboard", gnt);
            end else begin
                cur    = exp_q.pop_front();
                active = 1'b1;
                len    = 0;
                chk("grant_vec", 32'(gnt), 32'(cur.g));
                chk("grant_id", 32'(gnt_id), 32'(cur.id));
            end
        end
        if (busy) len++;
        if (!busy && busy_q && active) begin
            chk("hold_len", 32'(len), 32'(cur.len));
            chk("timeout_flag", 32'(timeout), 32'(cur.to));
            active = 1'b0;
        end
        if (timeout) chk("timeout_pulse", {30'd0, busy, to_q}, 32'd0);
        busy_q = busy;
        to_q   = timeout;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input logic v);
        int n = 0;
        while (busy !== v && n < 60) begin
            tick();
            n++;
        end
        if (busy !== v) begin
            checks++;
            errors++;
            $display("FAIL wait_busy: busy=%b never reached %b", busy, v);
        end
    endtask

    // wait for a grant, keep it n cycles, then apply new req/done on the exit edge
    task automatic hold_then(input int n, input logic [3:0] nreq, input logic ndone);
        wait_busy(1'b1);
        repeat (n - 1) tick();
        req  = nreq;
        done = ndone;
        tick();
        done = 1'b0;
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        req  = 4'b0000;
        done = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_gnt_id", 32'(gnt_id), 32'd0);
        chk("reset_busy_timeout", {30'd0, busy, timeout}, 32'd0);

        // full rotation with done each grant
        push(4'b0001, 2'd0, 2, 1'b0);
        push(4'b0010, 2'd1, 2, 1'b0);
        push(4'b0100, 2'd2, 2, 1'b0);
        push(4'b1000, 2'd3, 2, 1'b0);
        push(4'b0001, 2'd0, 2, 1'b0);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) hold_then(2, (i == 4) ? 4'b0000 : 4'b1111, 1'b1);
        repeat (2) tick();

        // hold limit: 8 cycles then timeout, then re-grant to the same requester
        do_reset();
        push(4'b0100, 2'd2, 8, 1'b1);
        push(4'b0100, 2'd2, 3, 1'b0);
        req = 4'b0100;
        wait_busy(1'b1);
        wait_busy(1'b0);
        hold_then(3, 4'b0000, 1'b0);
        repeat (2) tick();

        // owner drops request: ptr moves to 2 so 1000 beats 0001
        do_reset();
        push(4'b0010, 2'd1, 3, 1'b0);
        push(4'b1000, 2'd3, 1, 1'b0);
        req = 4'b0010;
        hold_then(3, 4'b1001, 1'b0);
        hold_then(1, 4'b0000, 1'b1);
        repeat (2) tick();

        // done coincident with the limit: no timeout, ptr advances to 1
        do_reset();
        push(4'b0001, 2'd0, 8, 1'b0);
        push(4'b0100, 2'd2, 1, 1'b0);
        req = 4'b0101;
        hold_then(8, 4'b0101, 1'b1);
        hold_then(1, 4'b0000, 1'b1);
        repeat (2) tick();

        // reset mid-grant, then requests 0011 and 0110 both expect ptr back at 0
        for (int k = 0; k < 2; k++) begin
            do_reset();
            push(4'b0010, 2'd1, 2, 1'b0);
            push((k == 0) ? 4'b0001 : 4'b0010, (k == 0) ? 2'd0 : 2'd1, 1, 1'b0);
            req = 4'b0010;
            wait_busy(1'b1);
            tick();
            rst = 1'b0;
            req = (k == 0) ? 4'b0011 : 4'b0110;
            tick();
            chk("midreset_gnt", 32'(gnt), 32'd0);
            chk("midreset_busy", 32'(busy), 32'd0);
            rst = 1'b1;
            hold_then(1, 4'b0000, 1'b1);
            repeat (2) tick();
        end

        // done in IDLE with no requests is ignored
        do_reset();
        done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_done", {26'd0, gnt, busy, timeout}, 32'd0);
        end
        done = 1'b0;

        repeat (3) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum number of consecutive cycles one requester SHALL hold the grant; legal range 2..255.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-low.
REQ-004 req  input  4  request vector; req[i] = requester i wants the shared resource.
REQ-005 done  input  1  owner release pulse; meaningful only while busy=1.
REQ-006 gnt  output  4  registered one-hot grant; all-zero when no owner.
REQ-007 gnt_id  output  2  binary index of the current owner; 0 when gnt=0.
REQ-008 busy  output  1  high exactly when gnt is non-zero.
REQ-009 timeout  output  1  one-cycle pulse when a grant is forcibly revoked at MAX_HOLD.

Function
REQ-010 FSM states SHALL be IDLE, GRANT and RELEASE.
REQ-011 IDLE: if req!=0, next state SHALL be GRANT, with gnt/gnt_id loaded with the winner; otherwise it SHALL stay IDLE with gnt=0.
REQ-012 The winner SHALL be the first set req bit found searching upward from pointer ptr, wrapping 3->0 (round-robin).
REQ-013 Grant latency SHALL be one cycle: req sampled at edge n gives gnt valid after edge n.
REQ-014 GRANT: the hold counter SHALL start at 0 and increment each cycle in GRANT.
REQ-015 GRANT: the FSM SHALL go to RELEASE when done=1, or req[gnt_id]=0, or the hold counter reaches MAX_HOLD-1.
REQ-016 RELEASE: gnt SHALL be 0 and busy SHALL be 0 for exactly one cycle.
REQ-017 ptr SHALL be loaded with (gnt_id+1) mod 4 on entry to RELEASE.
REQ-018 RELEASE: if req!=0, next state SHALL be GRANT (arbitrating with the updated ptr); otherwise IDLE.
REQ-019 timeout SHALL pulse high during the RELEASE cycle only when exit was caused solely by the counter limit.
REQ-020 If done=1 (or the owner's req drops) in the same cycle the limit is reached, timeout SHALL stay 0.
REQ-021 done asserted in IDLE or RELEASE SHALL be ignored.
REQ-022 gnt SHALL never have more than one bit set.
REQ-023 gnt SHALL never be asserted to a requester whose req was 0 at the arbitration edge.
REQ-024 Hold-counter width SHALL be $clog2(MAX_HOLD)+1; the counter SHALL never wrap.

Reset
REQ-025 rst=0 at a clock edge SHALL force state=IDLE, ptr=0, counter=0, gnt=0, gnt_id=0, busy=0 and timeout=0.
REQ-026 Reset asserted mid-grant SHALL drop gnt on the next edge, with no timeout pulse and no ptr advance.
REQ-027 The first arbitration after reset SHALL give req[0] highest priority.

Structure
REQ-028 The state enum (IDLE/GRANT/RELEASE), requester count 4 and grant-index width 2 SHALL live in shared package arb_pkg.
REQ-029 The rotate-and-select logic SHALL be one combinational sub-module, rr_pick4, with inputs req[3:0] and ptr[1:0] and outputs idx[1:0] and any.
REQ-030 rr_pick4 SHALL rotate req by ptr and apply a fixed lowest-index-first priority encoder.

Verification
REQ-031 Reset, then req=4'b1111 held, done pulsed each grant: gnt SHALL sequence 0001, 0010, 0100, 1000, 0001, with a one-cycle gnt=0 gap between grants.
REQ-032 req=4'b0100 held, done never asserted, MAX_HOLD=8: gnt=0100 SHALL last 8 cycles, then timeout=1 for one cycle with gnt=0; the re-grant to 0100 SHALL follow.
REQ-033 Owner 1 holding, req[1] dropped with req=4'b1001: next grant SHALL be 1000 (ptr=2), not 0001.
REQ-034 done and the counter limit coincident: timeout SHALL stay 0 and ptr SHALL advance.
REQ-035 rst=0 during GRANT with gnt=0010: after the next edge gnt=0, busy=0 and ptr=0; with req=4'b0011 after reset, gnt SHALL be 0001.
REQ-036 req=0 and done=1 pulsed in IDLE: gnt, busy and timeout SHALL all stay 0.
